// File: rtl/fetch_pkg.sv
// Shared types and widths for the PC fetch sequencer: FSM states and the
// {pc, instr} entry carried from instruction memory to decode.
package fetch_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch sequencer bus: redirect input, instruction-memory request/response
// channel and the decode-side instruction stream.
interface pc_fetch_sequencer_if;
  import fetch_pkg::*;

  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               imem_req_valid;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_req_ready;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               out_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries with synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output logic             head_valid,
  output fetch_entry_t     head_entry,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign head_valid = (count != '0);
  assign push_ok    = push && (count != CNT_W'(DEPTH));
  assign pop_ok     = pop && head_valid;
  assign head_entry = mem[rd_ptr];

  // NOTE: the storage array is not reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Instruction-fetch front end: single-outstanding fetch FSM, PC tagging of
// responses, and redirect handling that flushes the queue and drains stale data.
module pc_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter logic [PC_W-1:0] PC_STEP  = 16'h0001,
  parameter int              QDEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  pc_fetch_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  fetch_state_e     state;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  req_pc;
  logic             outstanding;
  logic             active;
  logic [CNT_W-1:0] count;
  logic             head_valid;
  fetch_entry_t     head_entry;
  fetch_entry_t     push_entry;
  logic             req_valid;
  logic             accept;
  logic             rsp_done;
  logic             still_outstanding;
  logic             push;
  logic             pop;

  // Slots already reserved by the in-flight request count against queue space.
  assign req_valid = active && (state == FETCH)
                     && ((int'(count) + int'(outstanding)) < QDEPTH);
  assign accept            = req_valid && bus.imem_req_ready;
  assign rsp_done          = outstanding && bus.imem_rsp_valid;
  assign still_outstanding = accept || (outstanding && !bus.imem_rsp_valid);
  assign push              = rsp_done && (state == WAIT) && !bus.redirect_valid;
  assign pop               = head_valid && bus.out_ready;
  assign push_entry        = '{pc: req_pc, instr: bus.imem_rsp_data};

  fetch_queue #(
    .DEPTH (QDEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (bus.redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_valid (head_valid),
    .head_entry (head_entry),
    .count      (count)
  );

  // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      active      <= 1'b0;
    end else begin
      active      <= 1'b1;
      outstanding <= still_outstanding;
      if (accept) req_pc <= fetch_pc;

      if (bus.redirect_valid) begin
        // A response still owed to the old path must be swallowed in DRAIN.
        fetch_pc <= bus.redirect_pc;
        state    <= still_outstanding ? DRAIN : FETCH;
      end else begin
        unique case (state)
          FETCH: begin
            if (accept) begin
              fetch_pc <= fetch_pc + PC_STEP;
              state    <= WAIT;
            end
          end
          WAIT, DRAIN: begin
            if (rsp_done) state <= FETCH;
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.out_valid      = head_valid;
  assign bus.out_pc         = head_valid ? head_entry.pc : '0;
  assign bus.out_instr      = head_valid ? head_entry.instr : '0;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer with a 1- or 2-cycle
// instruction-memory model whose data is the fetch address XOR a salt.
module tb_pc_fetch_sequencer;
  import fetch_pkg::*;

  localparam logic [INSTR_W-1:0] SALT = 16'hA5A5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer #(
    .RESET_PC (16'h0000),
    .PC_STEP  (16'h0001),
    .QDEPTH   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic               auto_mem      = 1'b1;
  int                 mem_lat       = 1;
  logic               man_rsp_valid = 1'b0;
  logic [INSTR_W-1:0] man_rsp_data  = '0;
  logic               mdl_valid     = 1'b0;
  logic [INSTR_W-1:0] mdl_data      = '0;
  logic               hs            = 1'b0;
  logic [PC_W-1:0]    hs_addr       = '0;
  logic               p1 = 1'b0, p2 = 1'b0;
  logic [PC_W-1:0]    a1 = '0, a2 = '0;
  fetch_entry_t       seen;

  logic [PC_W-1:0] acc_q[$];
  fetch_entry_t    out_q[$];

  assign bus.imem_rsp_valid = auto_mem ? mdl_valid : man_rsp_valid;
  assign bus.imem_rsp_data  = auto_mem ? mdl_data : man_rsp_data;

  // Memory model and monitors: handshakes sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      hs      = bus.imem_req_valid && bus.imem_req_ready;
      hs_addr = bus.imem_req_addr;
      if (hs) acc_q.push_back(hs_addr);
      if (bus.out_valid && bus.out_ready) begin
        seen.pc    = bus.out_pc;
        seen.instr = bus.out_instr;
        out_q.push_back(seen);
      end
      @(posedge clk);
      #1;
      p2 = p1;
      a2 = a1;
      p1 = hs && auto_mem;
      a1 = hs_addr;
      mdl_valid = (mem_lat == 1) ? p1 : p2;
      mdl_data  = ((mem_lat == 1) ? a1 : a2) ^ SALT;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    acc_q.delete();
    out_q.delete();
  endtask

  task automatic wait_acc(input logic [PC_W-1:0] addr, input string name);
    bit found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (acc_q.size() != 0 && acc_q[$] == addr) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL %s no accept of addr %h within budget", name, addr); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b1;
    auto_mem = 1'b1;
    mem_lat  = 1;
    repeat (3) tick();
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", bus.imem_req_valid); end
    checks++; if (bus.imem_req_addr !== 16'h0000) begin errors++; $display("FAIL reset_req_addr got=%h exp=0000", bus.imem_req_addr); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_pc !== 16'h0000) begin errors++; $display("FAIL reset_out_pc got=%h exp=0000", bus.out_pc); end
    checks++; if (bus.out_instr !== 16'h0000) begin errors++; $display("FAIL reset_out_instr got=%h exp=0000", bus.out_instr); end
  endtask

  task automatic test_sequential();
    reset_dut();
    repeat (14) tick();
    checks++; if (acc_q.size() != 7) begin errors++; $display("FAIL seq_accept_count got=%0d exp=7", acc_q.size()); end
    checks++; if (out_q.size() != 6) begin errors++; $display("FAIL seq_out_count got=%0d exp=6", out_q.size()); end
    for (int i = 0; i < 7 && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== PC_W'(i)) begin errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, acc_q[i], PC_W'(i)); end
    end
    for (int i = 0; i < 6 && i < out_q.size(); i++) begin
      checks++; if (out_q[i].pc !== PC_W'(i) || out_q[i].instr !== (INSTR_W'(i) ^ SALT)) begin
        errors++; $display("FAIL seq_out[%0d] got=%h/%h exp=%h/%h", i, out_q[i].pc, out_q[i].instr, PC_W'(i), INSTR_W'(i) ^ SALT);
      end
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    reset_dut();
    repeat (12) tick();
    checks++; if (acc_q.size() != 2) begin errors++; $display("FAIL bp_fetches got=%0d exp=2", acc_q.size()); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got=%b exp=0", bus.imem_req_valid); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000) begin
      errors++; $display("FAIL bp_head got=%b/%h exp=1/0000", bus.out_valid, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    repeat (12) tick();
    checks++; if (out_q.size() < 3) begin errors++; $display("FAIL bp_drain_count got=%0d exp>=3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      checks++; if (out_q[i].pc !== PC_W'(i)) begin errors++; $display("FAIL bp_drain_pc[%0d] got=%h exp=%h", i, out_q[i].pc, PC_W'(i)); end
    end
    checks++; if (acc_q.size() < 3 || acc_q[2] !== 16'h0002) begin errors++; $display("FAIL bp_resume_addr exp=0002 size=%0d", acc_q.size()); end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 2;
    reset_dut();
    wait_acc(16'h0005, "rw_reach_0005");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0100;
    tick();
    bus.redirect_valid = 1'b0;
    acc_q.delete();
    out_q.delete();
    checks++; if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rw_drain_idle got req=%b out=%b exp=0/0", bus.imem_req_valid, bus.out_valid);
    end
    repeat (12) tick();
    checks++; if (acc_q.size() == 0 || acc_q[0] !== 16'h0100) begin errors++; $display("FAIL rw_first_addr exp=0100 size=%0d", acc_q.size()); end
    checks++; if (out_q.size() == 0 || out_q[0].pc !== 16'h0100 || out_q[0].instr !== (16'h0100 ^ SALT)) begin
      errors++; $display("FAIL rw_first_out exp=0100/%h size=%0d", 16'h0100 ^ SALT, out_q.size());
    end
    foreach (out_q[i]) begin
      checks++; if (out_q[i].pc === 16'h0005) begin errors++; $display("FAIL rw_stale_seen got=%h exp=not 0005", out_q[i].pc); end
    end
    mem_lat = 1;
  endtask

  task automatic test_redirect_stall();
    bus.imem_req_ready = 1'b0;
    reset_dut();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0010;
    tick();
    bus.redirect_valid = 1'b0;
    acc_q.delete();
    out_q.delete();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'h0010) begin
      errors++; $display("FAIL rs_cycle1 got=%b/%h exp=1/0010", bus.imem_req_valid, bus.imem_req_addr);
    end
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0200;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'h0200) begin
      errors++; $display("FAIL rs_retarget got=%b/%h exp=1/0200", bus.imem_req_valid, bus.imem_req_addr);
    end
    tick();
    bus.imem_req_ready = 1'b1;
    repeat (8) tick();
    checks++; if (acc_q.size() == 0 || acc_q[0] !== 16'h0200) begin errors++; $display("FAIL rs_first_accept exp=0200 size=%0d", acc_q.size()); end
    foreach (acc_q[i]) begin
      checks++; if (acc_q[i] === 16'h0010) begin errors++; $display("FAIL rs_old_accepted got=%h exp=never", acc_q[i]); end
    end
    checks++; if (out_q.size() == 0 || out_q[0].pc !== 16'h0200) begin errors++; $display("FAIL rs_first_out exp=0200 size=%0d", out_q.size()); end
  endtask

  task automatic test_back_to_back();
    bus.imem_req_ready = 1'b0;
    reset_dut();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0300;
    tick();
    bus.redirect_pc    = 16'h0400;
    tick();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.imem_req_addr !== 16'h0400) begin errors++; $display("FAIL b2b_last_wins got=%h exp=0400", bus.imem_req_addr); end
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b0;
    acc_q.delete();
    repeat (12) tick();
    checks++; if (acc_q.size() == 0 || acc_q[0] !== 16'h0400) begin errors++; $display("FAIL b2b_first_accept exp=0400 size=%0d", acc_q.size()); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0400) begin
      errors++; $display("FAIL b2b_full_head got=%b/%h exp=1/0400", bus.out_valid, bus.out_pc);
    end
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0500;
    tick();
    bus.redirect_valid = 1'b0;
    out_q.delete();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_flush got=%b exp=0", bus.out_valid); end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 16'h0500) begin
      errors++; $display("FAIL b2b_flush_req got=%b/%h exp=1/0500", bus.imem_req_valid, bus.imem_req_addr);
    end
    repeat (8) tick();
    checks++; if (out_q.size() == 0 || out_q[0].pc !== 16'h0500) begin errors++; $display("FAIL b2b_after_flush exp=0500 size=%0d", out_q.size()); end
  endtask

  task automatic test_wrap();
    reset_dut();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFF;
    tick();
    bus.redirect_valid = 1'b0;
    acc_q.delete();
    out_q.delete();
    repeat (10) tick();
    checks++; if (acc_q.size() < 2 || acc_q[0] !== 16'hFFFF || acc_q[1] !== 16'h0000) begin
      errors++; $display("FAIL wrap_addrs exp=FFFF,0000 size=%0d", acc_q.size());
    end
    checks++; if (out_q.size() < 3 || out_q[0].pc !== 16'hFFFF || out_q[1].pc !== 16'h0000 || out_q[2].pc !== 16'h0001) begin
      errors++; $display("FAIL wrap_out_pcs exp=FFFF,0000,0001 size=%0d", out_q.size());
    end
  endtask

  task automatic test_reset_mid_wait();
    auto_mem      = 1'b0;
    man_rsp_valid = 1'b0;
    reset_dut();
    wait_acc(16'h0000, "rmw_reach_wait");
    rst_n = 1'b0;
    tick();
    checks++; if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rmw_reset_valids got=%b/%b exp=0/0", bus.imem_req_valid, bus.out_valid);
    end
    checks++; if (bus.imem_req_addr !== 16'h0000 || bus.out_pc !== 16'h0000 || bus.out_instr !== 16'h0000) begin
      errors++; $display("FAIL rmw_reset_data got=%h/%h/%h exp=0", bus.imem_req_addr, bus.out_pc, bus.out_instr);
    end
    rst_n         = 1'b1;
    man_rsp_valid = 1'b1;
    man_rsp_data  = 16'hDEAD;
    tick();
    man_rsp_valid = 1'b0;
    auto_mem      = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmw_late_rsp got=%b exp=0", bus.out_valid); end
    acc_q.delete();
    out_q.delete();
    repeat (10) tick();
    checks++; if (out_q.size() == 0 || out_q[0].pc !== 16'h0000 || out_q[0].instr !== (16'h0000 ^ SALT)) begin
      errors++; $display("FAIL rmw_first_out exp=0000/%h size=%0d", 16'h0000 ^ SALT, out_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_stall();
    test_back_to_back();
    test_wrap();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
